// File: rtl/axi_reg_slice.sv
// axi_reg_slice_buf: one AXI channel stage, selectable as bypass, 2-entry skid or 1-entry buffer.
// Latency: 0 cycles in bypass, 1 cycle s->m in full and light modes.
// Backpressure: s_rdy is registered and drops only when the stage holds its maximum beat count.
module axi_reg_slice_buf #(
  parameter int WIDTH = 32,
  parameter int MODE  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_dat,
  input  logic             s_vld,
  output logic             s_rdy,
  output logic [WIDTH-1:0] m_dat,
  output logic             m_vld,
  input  logic             m_rdy
);

  if (MODE == 0) begin : g_bypass
    // Pure wires: no state, so clock and reset are intentionally unused here.
    wire unused_clk_rst = clk & rst_n;
    assign m_dat = s_dat;
    assign m_vld = s_vld;
    assign s_rdy = m_rdy;
  end else if (MODE == 1) begin : g_full
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]       state, state_nxt;
    logic [WIDTH-1:0] main_q, skid_q;
    logic             s_rdy_q, m_vld_q;
    logic             accept, drain;

    assign accept = s_vld & s_rdy_q;
    assign drain  = m_vld_q & m_rdy;
    assign s_rdy  = s_rdy_q;
    assign m_vld  = m_vld_q;
    assign m_dat  = main_q;

    // Occupancy after this cycle's handshakes.
    always_comb begin
      state_nxt = state;
      case (state)
        ST_EMPTY: if (accept) state_nxt = ST_ONE;
        ST_ONE: begin
          if (accept && !drain) state_nxt = ST_TWO;
          else if (!accept && drain) state_nxt = ST_EMPTY;
        end
        ST_TWO:   if (drain) state_nxt = ST_ONE;
        default:  state_nxt = ST_EMPTY;
      endcase
    end

    // State plus registered handshake outputs; ready stays low through reset and rises on the first edge after.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state   <= ST_EMPTY;
        s_rdy_q <= 1'b0;
        m_vld_q <= 1'b0;
      end else begin
        state   <= state_nxt;
        s_rdy_q <= (state_nxt != ST_TWO);
        m_vld_q <= (state_nxt != ST_EMPTY);
      end
    end

    // Payload: main holds the head beat, skid catches the beat accepted while main is stalled.
    always_ff @(posedge clk) begin
      case (state)
        ST_EMPTY: if (accept) main_q <= s_dat;
        ST_ONE: begin
          if (accept && drain) main_q <= s_dat;
          else if (accept) skid_q <= s_dat;
        end
        ST_TWO:   if (drain) main_q <= skid_q;
        default:  ;
      endcase
    end
  end else if (MODE == 2) begin : g_light
    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    logic             state, state_nxt;
    logic [WIDTH-1:0] data_q;
    logic             s_rdy_q, m_vld_q;
    logic             accept, drain;

    assign accept = s_vld & s_rdy_q;
    assign drain  = m_vld_q & m_rdy;
    assign s_rdy  = s_rdy_q;
    assign m_vld  = m_vld_q;
    assign m_dat  = data_q;

    // Single slot: fill when empty, empty when drained; the two never coincide.
    always_comb begin
      state_nxt = state;
      case (state)
        ST_EMPTY: if (accept) state_nxt = ST_FULL;
        ST_FULL:  if (drain) state_nxt = ST_EMPTY;
        default:  state_nxt = ST_EMPTY;
      endcase
    end

    // State plus registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state   <= ST_EMPTY;
        s_rdy_q <= 1'b0;
        m_vld_q <= 1'b0;
      end else begin
        state   <= state_nxt;
        s_rdy_q <= (state_nxt == ST_EMPTY);
        m_vld_q <= (state_nxt == ST_FULL);
      end
    end

    // Payload capture on accept only; held stable while the beat waits.
    always_ff @(posedge clk) begin
      if (accept) data_q <= s_dat;
    end
  end else begin : g_bad_mode
    $error("axi_reg_slice_buf: MODE must be 0, 1 or 2");
    assign m_dat = '0;
    assign m_vld = 1'b0;
    assign s_rdy = 1'b0;
  end

endmodule

// axi_reg_slice: AXI4 register slice, five independent channel stages between slave and master ports.
// Latency: per channel, 0 cycles (bypass) or 1 cycle (full / light).
// Backpressure: each channel's ready is that stage's registered ready, or the far-side ready in bypass.
module axi_reg_slice #(
  parameter int C_S_AXI_DATA_WIDTH = 64,
  parameter int C_S_AXI_ADDR_WIDTH = 7,
  parameter int C_AW_MODE          = 1,
  parameter int C_W_MODE           = 1,
  parameter int C_B_MODE           = 2,
  parameter int C_AR_MODE          = 1,
  parameter int C_R_MODE           = 1
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [7:0]                        S_AXI_AWLEN,
  input  logic [2:0]                        S_AXI_AWSIZE,
  input  logic [1:0]                        S_AXI_AWBURST,
  input  logic                              S_AXI_AWLOCK,
  input  logic [3:0]                        S_AXI_AWCACHE,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic [3:0]                        S_AXI_AWQOS,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WLAST,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [7:0]                        S_AXI_ARLEN,
  input  logic [2:0]                        S_AXI_ARSIZE,
  input  logic [1:0]                        S_AXI_ARBURST,
  input  logic                              S_AXI_ARLOCK,
  input  logic [3:0]                        S_AXI_ARCACHE,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic [3:0]                        S_AXI_ARQOS,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RLAST,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [7:0]                        M_AXI_AWLEN,
  output logic [2:0]                        M_AXI_AWSIZE,
  output logic [1:0]                        M_AXI_AWBURST,
  output logic                              M_AXI_AWLOCK,
  output logic [3:0]                        M_AXI_AWCACHE,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic [3:0]                        M_AXI_AWQOS,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WLAST,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [7:0]                        M_AXI_ARLEN,
  output logic [2:0]                        M_AXI_ARSIZE,
  output logic [1:0]                        M_AXI_ARBURST,
  output logic                              M_AXI_ARLOCK,
  output logic [3:0]                        M_AXI_ARCACHE,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic [3:0]                        M_AXI_ARQOS,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RLAST,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int AX_W = C_S_AXI_ADDR_WIDTH + 25;
  localparam int W_W  = C_S_AXI_DATA_WIDTH + C_S_AXI_DATA_WIDTH / 8 + 1;
  localparam int R_W  = C_S_AXI_DATA_WIDTH + 3;

  if ((C_S_AXI_DATA_WIDTH % 8) != 0 || C_S_AXI_DATA_WIDTH < 32 || C_S_AXI_DATA_WIDTH > 1024) begin : g_bad_dw
    $error("axi_reg_slice: C_S_AXI_DATA_WIDTH must be a multiple of 8 in 32..1024");
  end
  if (C_S_AXI_ADDR_WIDTH < 1 || C_S_AXI_ADDR_WIDTH > 64) begin : g_bad_aw
    $error("axi_reg_slice: C_S_AXI_ADDR_WIDTH must be in 1..64");
  end

  logic [AX_W-1:0] aw_in, aw_out, ar_in, ar_out;
  logic [W_W-1:0]  w_in, w_out;
  logic [1:0]      b_in, b_out;
  logic [R_W-1:0]  r_in, r_out;

  // Payloads packed in port-list order; the stages never look inside them.
  assign aw_in = {S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST,
                  S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS};
  assign {M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
          M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS} = aw_out;
  assign w_in  = {S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST};
  assign {M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST} = w_out;
  assign b_in  = M_AXI_BRESP;
  assign S_AXI_BRESP = b_out;
  assign ar_in = {S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST,
                  S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS};
  assign {M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
          M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS} = ar_out;
  assign r_in  = {M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST};
  assign {S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST} = r_out;

  axi_reg_slice_buf #(.WIDTH(AX_W), .MODE(C_AW_MODE)) u_aw (
    .clk(aclk), .rst_n(aresetn),
    .s_dat(aw_in), .s_vld(S_AXI_AWVALID), .s_rdy(S_AXI_AWREADY),
    .m_dat(aw_out), .m_vld(M_AXI_AWVALID), .m_rdy(M_AXI_AWREADY));

  axi_reg_slice_buf #(.WIDTH(W_W), .MODE(C_W_MODE)) u_w (
    .clk(aclk), .rst_n(aresetn),
    .s_dat(w_in), .s_vld(S_AXI_WVALID), .s_rdy(S_AXI_WREADY),
    .m_dat(w_out), .m_vld(M_AXI_WVALID), .m_rdy(M_AXI_WREADY));

  // Response channels flow master side -> slave side.
  axi_reg_slice_buf #(.WIDTH(2), .MODE(C_B_MODE)) u_b (
    .clk(aclk), .rst_n(aresetn),
    .s_dat(b_in), .s_vld(M_AXI_BVALID), .s_rdy(M_AXI_BREADY),
    .m_dat(b_out), .m_vld(S_AXI_BVALID), .m_rdy(S_AXI_BREADY));

  axi_reg_slice_buf #(.WIDTH(AX_W), .MODE(C_AR_MODE)) u_ar (
    .clk(aclk), .rst_n(aresetn),
    .s_dat(ar_in), .s_vld(S_AXI_ARVALID), .s_rdy(S_AXI_ARREADY),
    .m_dat(ar_out), .m_vld(M_AXI_ARVALID), .m_rdy(M_AXI_ARREADY));

  axi_reg_slice_buf #(.WIDTH(R_W), .MODE(C_R_MODE)) u_r (
    .clk(aclk), .rst_n(aresetn),
    .s_dat(r_in), .s_vld(M_AXI_RVALID), .s_rdy(M_AXI_RREADY),
    .m_dat(r_out), .m_vld(S_AXI_RVALID), .m_rdy(S_AXI_RREADY));

endmodule

// File: tb/tb_axi_reg_slice.sv
// Bench for axi_reg_slice: one instance with the default channel modes, one with every channel bypassed.
// Channels are handled generically as source -> sink pairs; index 0..4 = AW,W,B,AR,R of the default
// instance, 5..9 the same channels of the bypass instance.
module tb_axi_reg_slice;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  logic [72:0] src_dat [10];
  logic        src_vld [10];
  logic        src_rdy [10];
  logic [72:0] dst_dat [10];
  logic        dst_vld [10];
  logic        dst_rdy [10];

  for (genvar d = 0; d < 2; d++) begin : g_dut
    wire [31:0] aw_m;
    wire [72:0] w_m;
    wire [1:0]  b_s;
    wire [31:0] ar_m;
    wire [66:0] r_s;
    assign dst_dat[5*d+0] = 73'(aw_m);
    assign dst_dat[5*d+1] = w_m;
    assign dst_dat[5*d+2] = 73'(b_s);
    assign dst_dat[5*d+3] = 73'(ar_m);
    assign dst_dat[5*d+4] = 73'(r_s);

    axi_reg_slice #(
      .C_S_AXI_DATA_WIDTH(64), .C_S_AXI_ADDR_WIDTH(7),
      .C_AW_MODE(d == 0 ? 1 : 0), .C_W_MODE(d == 0 ? 1 : 0), .C_B_MODE(d == 0 ? 2 : 0),
      .C_AR_MODE(d == 0 ? 1 : 0), .C_R_MODE(d == 0 ? 1 : 0)
    ) u_dut (
      .aclk(aclk), .aresetn(aresetn),
      .S_AXI_AWADDR(src_dat[5*d+0][31:25]), .S_AXI_AWLEN(src_dat[5*d+0][24:17]),
      .S_AXI_AWSIZE(src_dat[5*d+0][16:14]), .S_AXI_AWBURST(src_dat[5*d+0][13:12]),
      .S_AXI_AWLOCK(src_dat[5*d+0][11]), .S_AXI_AWCACHE(src_dat[5*d+0][10:7]),
      .S_AXI_AWPROT(src_dat[5*d+0][6:4]), .S_AXI_AWQOS(src_dat[5*d+0][3:0]),
      .S_AXI_AWVALID(src_vld[5*d+0]), .S_AXI_AWREADY(src_rdy[5*d+0]),
      .S_AXI_WDATA(src_dat[5*d+1][72:9]), .S_AXI_WSTRB(src_dat[5*d+1][8:1]),
      .S_AXI_WLAST(src_dat[5*d+1][0]),
      .S_AXI_WVALID(src_vld[5*d+1]), .S_AXI_WREADY(src_rdy[5*d+1]),
      .S_AXI_BRESP(b_s), .S_AXI_BVALID(dst_vld[5*d+2]), .S_AXI_BREADY(dst_rdy[5*d+2]),
      .S_AXI_ARADDR(src_dat[5*d+3][31:25]), .S_AXI_ARLEN(src_dat[5*d+3][24:17]),
      .S_AXI_ARSIZE(src_dat[5*d+3][16:14]), .S_AXI_ARBURST(src_dat[5*d+3][13:12]),
      .S_AXI_ARLOCK(src_dat[5*d+3][11]), .S_AXI_ARCACHE(src_dat[5*d+3][10:7]),
      .S_AXI_ARPROT(src_dat[5*d+3][6:4]), .S_AXI_ARQOS(src_dat[5*d+3][3:0]),
      .S_AXI_ARVALID(src_vld[5*d+3]), .S_AXI_ARREADY(src_rdy[5*d+3]),
      .S_AXI_RDATA(r_s[66:3]), .S_AXI_RRESP(r_s[2:1]), .S_AXI_RLAST(r_s[0]),
      .S_AXI_RVALID(dst_vld[5*d+4]), .S_AXI_RREADY(dst_rdy[5*d+4]),
      .M_AXI_AWADDR(aw_m[31:25]), .M_AXI_AWLEN(aw_m[24:17]), .M_AXI_AWSIZE(aw_m[16:14]),
      .M_AXI_AWBURST(aw_m[13:12]), .M_AXI_AWLOCK(aw_m[11]), .M_AXI_AWCACHE(aw_m[10:7]),
      .M_AXI_AWPROT(aw_m[6:4]), .M_AXI_AWQOS(aw_m[3:0]),
      .M_AXI_AWVALID(dst_vld[5*d+0]), .M_AXI_AWREADY(dst_rdy[5*d+0]),
      .M_AXI_WDATA(w_m[72:9]), .M_AXI_WSTRB(w_m[8:1]), .M_AXI_WLAST(w_m[0]),
      .M_AXI_WVALID(dst_vld[5*d+1]), .M_AXI_WREADY(dst_rdy[5*d+1]),
      .M_AXI_BRESP(src_dat[5*d+2][1:0]), .M_AXI_BVALID(src_vld[5*d+2]), .M_AXI_BREADY(src_rdy[5*d+2]),
      .M_AXI_ARADDR(ar_m[31:25]), .M_AXI_ARLEN(ar_m[24:17]), .M_AXI_ARSIZE(ar_m[16:14]),
      .M_AXI_ARBURST(ar_m[13:12]), .M_AXI_ARLOCK(ar_m[11]), .M_AXI_ARCACHE(ar_m[10:7]),
      .M_AXI_ARPROT(ar_m[6:4]), .M_AXI_ARQOS(ar_m[3:0]),
      .M_AXI_ARVALID(dst_vld[5*d+3]), .M_AXI_ARREADY(dst_rdy[5*d+3]),
      .M_AXI_RDATA(src_dat[5*d+4][66:3]), .M_AXI_RRESP(src_dat[5*d+4][2:1]),
      .M_AXI_RLAST(src_dat[5*d+4][0]),
      .M_AXI_RVALID(src_vld[5*d+4]), .M_AXI_RREADY(src_rdy[5*d+4])
    );
  end

  int checks = 0;
  int errors = 0;

  // Reference model: per channel, a queue of accepted-but-not-delivered beats.
  logic [72:0] sb [10][$];
  bit          hold  [10];
  bit          stall [10];
  logic [72:0] stall_dat [10];
  int          beats [10];

  typedef struct {
    logic       vld;
    logic [1:0] resp;
    logic       rdy;
    logic       exp_vld;
    logic [1:0] exp_resp;
    logic       exp_src_rdy;
  } bvec_t;
  bvec_t tbl [12];

  function automatic int ch_mode(int k);
    if (k >= 5) return 0;
    if (k == 2) return 2;
    return 1;
  endfunction

  function automatic int ch_width(int k);
    case (k % 5)
      0, 3:    return 32;
      1:       return 73;
      2:       return 2;
      default: return 67;
    endcase
  endfunction

  function automatic logic [72:0] rnd_pay(int k);
    logic [95:0] r;
    logic [72:0] one, mask;
    r    = {$urandom, $urandom, $urandom};
    one  = 73'd1;
    mask = (one << ch_width(k)) - one;
    return r[72:0] & mask;
  endfunction

  function automatic logic [72:0] aw_beat(int n);
    return 73'({7'(n), 25'h0AB_CDEF ^ 25'(n)});
  endfunction

  function automatic logic [72:0] w_beat(int n);
    return {32'h0, 32'hA5A5_0000 + 32'(n), 8'hFF, 1'(n == 7)};
  endfunction

  task automatic chk(input string name, input int k, input logic [72:0] act, input logic [72:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s ch%0d: got %h, expected %h", name, k, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input int k, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s ch%0d: got %b, expected %b", name, k, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic run_random(input int max_cycles, input int target);
    int n;
    bit done;
    for (int cyc = 0; cyc < max_cycles; cyc++) begin
      step();
      for (int k = 0; k < 10; k++) begin
        if (!hold[k]) begin
          src_vld[k] = ($urandom_range(0, 3) != 0);
          src_dat[k] = rnd_pay(k);
        end
        dst_rdy[k] = ($urandom_range(0, 3) != 0);
      end
      #1;
      for (int k = 0; k < 10; k++) begin
        n = sb[k].size();
        if (ch_mode(k) == 0) begin
          chk_bit("byp_vld", k, dst_vld[k], src_vld[k]);
          chk_bit("byp_rdy", k, src_rdy[k], dst_rdy[k]);
          chk("byp_dat", k, dst_dat[k], src_dat[k]);
        end else begin
          chk_bit("occ_rdy", k, src_rdy[k], (ch_mode(k) == 1) ? (n < 2) : (n == 0));
          chk_bit("occ_vld", k, dst_vld[k], n != 0);
        end
        if (stall[k]) begin
          chk_bit("stable_vld", k, dst_vld[k], 1'b1);
          chk("stable_dat", k, dst_dat[k], stall_dat[k]);
        end
        if (src_vld[k] && src_rdy[k]) sb[k].push_back(src_dat[k]);
        if (dst_vld[k] && dst_rdy[k]) begin
          if (sb[k].size() == 0) chk_bit("no_phantom_beat", k, 1'b1, 1'b0);
          else chk("order_dat", k, dst_dat[k], sb[k].pop_front());
          beats[k]++;
        end
        hold[k]      = src_vld[k] && !src_rdy[k];
        stall[k]     = dst_vld[k] && !dst_rdy[k];
        stall_dat[k] = dst_dat[k];
      end
      done = 1'b1;
      for (int k = 0; k < 5; k++) if (beats[k] < target) done = 1'b0;
      if (done) break;
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 10; k++) begin
      sb[k].delete();
      hold[k]    = 1'b0;
      stall[k]   = 1'b0;
      beats[k]   = 0;
      src_vld[k] = 1'b0;
    end
  endtask

  initial begin
    int sent, rcvd, low_cnt;
    aresetn = 1'b0;
    for (int k = 0; k < 10; k++) begin
      src_dat[k] = '0;
      src_vld[k] = 1'b0;
      dst_rdy[k] = 1'b0;
    end
    clear_model();

    // Light-mode B channel, cycle by cycle: {M bvalid, M bresp, S bready} -> {S bvalid, S bresp, M bready}
    tbl[0]  = '{1'b1, 2'd0, 1'b1, 1'b0, 2'd0, 1'b1};
    tbl[1]  = '{1'b1, 2'd2, 1'b1, 1'b1, 2'd0, 1'b0};
    tbl[2]  = '{1'b1, 2'd2, 1'b1, 1'b0, 2'd0, 1'b1};
    tbl[3]  = '{1'b1, 2'd3, 1'b1, 1'b1, 2'd2, 1'b0};
    tbl[4]  = '{1'b1, 2'd3, 1'b1, 1'b0, 2'd0, 1'b1};
    tbl[5]  = '{1'b0, 2'd0, 1'b1, 1'b1, 2'd3, 1'b0};
    tbl[6]  = '{1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b1};
    tbl[7]  = '{1'b1, 2'd1, 1'b1, 1'b0, 2'd0, 1'b1};
    tbl[8]  = '{1'b0, 2'd0, 1'b0, 1'b1, 2'd1, 1'b0};
    tbl[9]  = '{1'b0, 2'd0, 1'b0, 1'b1, 2'd1, 1'b0};
    tbl[10] = '{1'b0, 2'd0, 1'b1, 1'b1, 2'd1, 1'b0};
    tbl[11] = '{1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 1'b1};

    // Reset held with AWVALID high: nothing valid, nothing ready; ready rises on first edge after release.
    src_vld[0] = 1'b1;
    repeat (3) step();
    for (int k = 0; k < 5; k++) begin
      chk_bit("rst_vld", k, dst_vld[k], 1'b0);
      chk_bit("rst_rdy", k, src_rdy[k], 1'b0);
    end
    aresetn = 1'b1;
    #1;
    chk_bit("rdy_before_edge", 0, src_rdy[0], 1'b0);
    step();
    for (int k = 0; k < 5; k++) chk_bit("rdy_after_edge", k, src_rdy[k], 1'b1);
    chk_bit("aw_not_taken_in_reset", 0, dst_vld[0], 1'b0);
    src_vld[0] = 1'b0;

    // Full-mode AW: 16 back-to-back beats, sink always ready -> 1-cycle latency, no bubbles.
    dst_rdy[0] = 1'b1;
    for (int n = 0; n < 18; n++) begin
      step();
      src_vld[0] = (n < 16);
      src_dat[0] = aw_beat(n);
      #1;
      if (n < 16) chk_bit("t2_rdy", 0, src_rdy[0], 1'b1);
      chk_bit("t2_vld", 0, dst_vld[0], (n >= 1) && (n <= 16));
      if (n >= 1 && n <= 16) chk("t2_dat", 0, dst_dat[0], aw_beat(n - 1));
    end
    src_vld[0] = 1'b0;

    // Full-mode W: 8-beat burst, sink stalls for 3 cycles mid-stream.
    sent = 0; rcvd = 0; low_cnt = 0;
    for (int c = 0; c < 40 && rcvd < 8; c++) begin
      step();
      dst_rdy[1] = !(c >= 3 && c <= 5);
      src_vld[1] = (sent < 8);
      src_dat[1] = w_beat(sent);
      #1;
      chk_bit("t3_rdy", 1, src_rdy[1], (sent - rcvd) < 2);
      if (!src_rdy[1]) low_cnt++;
      if (src_vld[1] && src_rdy[1]) sent++;
      if (dst_vld[1] && dst_rdy[1]) begin
        chk("t3_dat", 1, dst_dat[1], w_beat(rcvd));
        rcvd++;
      end
    end
    chk("t3_beats", 1, 73'(rcvd), 73'(8));
    chk("t3_rdy_low_cycles", 1, 73'(low_cnt), 73'(3));
    src_vld[1] = 1'b0;

    // Light-mode B: table-driven.
    for (int i = 0; i < 12; i++) begin
      step();
      src_vld[2] = tbl[i].vld;
      src_dat[2] = 73'(tbl[i].resp);
      dst_rdy[2] = tbl[i].rdy;
      #1;
      chk_bit("t4_bvalid", i, dst_vld[2], tbl[i].exp_vld);
      chk_bit("t4_bready", i, src_rdy[2], tbl[i].exp_src_rdy);
      if (tbl[i].exp_vld) chk("t4_bresp", i, dst_dat[2], 73'(tbl[i].exp_resp));
    end
    src_vld[2] = 1'b0;

    // Random traffic on every channel of both instances.
    run_random(2000, 1 << 30);

    // Asynchronous reset mid-traffic: outputs must drop without waiting for a clock edge.
    #3;
    aresetn = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk_bit("async_rst_vld", k, dst_vld[k], 1'b0);
      chk_bit("async_rst_rdy", k, src_rdy[k], 1'b0);
    end
    clear_model();
    repeat (2) step();
    aresetn = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      chk_bit("rerst_rdy", k, src_rdy[k], 1'b1);
      chk_bit("rerst_vld", k, dst_vld[k], 1'b0);
    end

    run_random(60000, 10000);
    for (int k = 0; k < 5; k++) chk_bit("beats_reached", k, beats[k] >= 10000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
